// File: rtl/isqrt_iter_fsm.sv
// Iterative restoring integer square root: y = floor(sqrt(x)) for a 32-bit radicand.
// Resolves BITS_PER_CYCLE result bits per clock, giving a fixed latency of 16/BITS_PER_CYCLE+1 cycles.
module isqrt_iter_fsm #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y,
    output logic        busy
);
    // Handshake: x_vld is a one-cycle request strobe, honoured only when busy is low
    // (IDLE or DONE); y_vld is a one-cycle strobe and y holds until the next result.
    localparam int ITER = 16 / BITS_PER_CYCLE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] x_sh;
    logic [17:0] rem;
    logic [15:0] root;
    logic [3:0]  cnt;

    logic [31:0] x_sh_nxt;
    logic [17:0] rem_nxt;
    logic [15:0] root_nxt;
    logic [17:0] trial;
    logic        accept;

    // BITS_PER_CYCLE unrolled restoring steps on the current partial remainder and root.
    always_comb begin
        x_sh_nxt = x_sh;
        rem_nxt  = rem;
        root_nxt = root;
        trial    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_nxt  = {rem_nxt[15:0], x_sh_nxt[31:30]};
            x_sh_nxt = {x_sh_nxt[29:0], 2'b00};
            trial    = {root_nxt, 2'b01};
            if (rem_nxt >= trial) begin
                rem_nxt  = rem_nxt - trial;
                root_nxt = {root_nxt[14:0], 1'b1};
            end else begin
                root_nxt = {root_nxt[14:0], 1'b0};
            end
        end
    end

    assign accept = x_vld && (state != CALC);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (x_vld) state_nxt = CALC;
            CALC:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = x_vld ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x_sh  <= '0;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            y     <= '0;
            y_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            y_vld <= 1'b0;
            if (accept) begin
                x_sh <= x;
                rem  <= '0;
                root <= '0;
                cnt  <= 4'(ITER - 1);
            end else if (state == CALC) begin
                x_sh <= x_sh_nxt;
                rem  <= rem_nxt;
                root <= root_nxt;
                cnt  <= cnt - 4'd1;
                if (cnt == 4'd0) begin
                    y     <= root_nxt;
                    y_vld <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == CALC);

endmodule

// File: doc/isqrt_iter_fsm.md
Name: isqrt_iter_fsm

Overview:
- Sequential integer square-root responder: y = floor(sqrt(x)) for a 32-bit unsigned x, 16-bit result.
- Sits on the responder side of the isqrt valid interface; formula FSMs drive x_vld/x and consume y_vld/y.
- Iterative digit-by-digit (restoring) algorithm, one result at a time, fixed latency.
- Fixed latency lets two parallel instances started in the same cycle return y_vld in the same cycle.

Parameters:
BITS_PER_CYCLE  1  result bits resolved per clock; legal values 1, 2, 4, 8, 16; ITER = 16 / BITS_PER_CYCLE

Ports:
clk    input   1   clock, rising edge
rst    input   1   reset, asynchronous, active-high
x_vld  input   1   request strobe; x is valid this cycle
x      input   32  unsigned radicand
y_vld  output  1   one-cycle strobe; y holds a new result
y      output  16  floor(sqrt(x)) of the last accepted request
busy   output  1   high while a computation is in progress; requests are dropped

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset (async assert, any state): state=IDLE, y_vld=0, y=0, busy=0, rem=0, root=0, iteration counter=0.
- States:
  - IDLE: accepts a request.
  - CALC: iterates.
  - DONE: y_vld=1; also accepts a request.
- Acceptance:
  - x_vld=1 in IDLE or DONE at cycle T captures x into the shift register.
  - Clears rem/root, loads counter=ITER-1, next state=CALC.
  - x_vld in CALC is ignored entirely: no capture, no error flag, running computation unaffected.
- Iteration (each CALC cycle repeats BITS_PER_CYCLE times combinationally):
  - rem = (rem<<2) | top 2 bits of x_sh; x_sh <<= 2.
  - trial = (root<<2) | 1.
  - If rem >= trial: rem -= trial; root = (root<<1)|1. Otherwise root = root<<1.
- Widths: rem 18 bits, trial 18 bits, root 16 bits. No overflow is possible by construction.
- Leaving CALC:
  - Counter decrements each CALC cycle.
  - At counter==0 the last step is done, y<=root, y_vld<=1, next state=DONE.
- Latency: y_vld high in exactly cycle T+ITER+1 (17 cycles for BITS_PER_CYCLE=1), independent of x value. High for exactly one cycle.
- DONE exit:
  - Always leaves DONE next cycle: to CALC if x_vld (back-to-back acceptance), else to IDLE.
  - Back-to-back throughput = one result per ITER+1 cycles.
- y holds its value until the next completion; it is not cleared when y_vld drops.
- busy = (state==CALC), combinational from state. 0 in IDLE and DONE.
- Reset mid-CALC: the computation is discarded, no y_vld is produced, and y returns to 0.
- Boundaries:
  - x=0 -> y=0.
  - x=32'hFFFFFFFF -> y=16'hFFFF.
  - Perfect squares are exact; non-squares truncate toward zero.

Test Plan:
- x_vld=1, x=16 at cycle T (BITS_PER_CYCLE=1) -> y_vld=1 only in cycle T+17, y=4; busy=1 in cycles T+1..T+16.
- x=0, then x=15, then x=32'hFFFFFFFF, each after the previous y_vld -> y=0, 3, 16'hFFFF respectively; each with latency 17.
- x_vld=1, x=100 asserted in the same cycle y_vld=1 for a prior x=81 -> y=9 that cycle; y=10 exactly 17 cycles later; no idle gap.
- x=144 accepted, then x_vld=1, x=4 during CALC -> single y_vld, y=12; no second result.
- x=1000000 accepted, rst pulsed 5 cycles later -> y_vld never asserts, y=0, busy=0. A following x=9 gives y=3 after 17 cycles.
- Two instances, x=49 and x=50 applied in the same cycle; repeat with BITS_PER_CYCLE=4 -> y_vld coincident, y=7 and y=7; latency 5 cycles for BITS_PER_CYCLE=4.
